// File: rtl/dram_bank_model_pkg.sv
// Shared encodings and default timing for the single-bank DRAM responder model.
// Command ops, violation codes, bank states and the timing-counter helper live here.
package dram_bank_model_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ACT = 3'd1,
    OP_RD  = 3'd2,
    OP_WR  = 3'd3,
    OP_PRE = 3'd4
  } op_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN   = 3'd1;
  localparam logic [2:0] ERR_COL_CLOSED = 3'd2;
  localparam logic [2:0] ERR_RCD        = 3'd3;
  localparam logic [2:0] ERR_CCD        = 3'd4;
  localparam logic [2:0] ERR_PRE_EARLY  = 3'd5;
  localparam logic [2:0] ERR_RP         = 3'd6;
  localparam logic [2:0] ERR_ILLEGAL_OP = 3'd7;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ACTIVATING  = 3'd1;
  localparam logic [2:0] S_ACTIVE      = 3'd2;
  localparam logic [2:0] S_AP_WAIT     = 3'd3;
  localparam logic [2:0] S_PRECHARGING = 3'd4;

  localparam int DEF_T_RCD = 3;
  localparam int DEF_T_RAS = 6;
  localparam int DEF_T_RP  = 3;
  localparam int DEF_T_CL  = 4;
  localparam int DEF_T_WR  = 3;
  localparam int DEF_T_CCD = 2;

  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] decSat(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) ? cnt : cnt - CNT_W'(1);
  endfunction

endpackage

// File: rtl/dram_bank_model_rd_latency_pipe.sv
// Fixed-latency valid/data delay line: a push appears on the outputs DEPTH cycles later.
// Data is zeroed alongside an empty slot so the output bus is quiet when valid is low.
module rd_latency_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= push_i;
      data_q[0]  <= push_i ? data_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/dram_bank_model.sv
// Device-side responder for one DRAM bank: tracks the open row, enforces bank
// timing, flags protocol violations and returns read strobes T_CL cycles after a legal RD.
module dram_bank_model
  import dram_bank_model_pkg::*;
#(
  parameter int BANK_ID   = 0,
  parameter int ADDR_BITS = 14,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RAS     = DEF_T_RAS,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_CL      = DEF_T_CL,
  parameter int T_WR      = DEF_T_WR,
  parameter int T_CCD     = DEF_T_CCD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [2:0]           cmd_bank,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  output logic                 row_open,
  output logic [ADDR_BITS-1:0] open_row,
  output logic                 bank_busy,
  output logic                 rd_valid,
  output logic [ADDR_BITS-1:0] rd_col,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [7:0]           err_count
);

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] openRow_q, openRow_d;
  logic [CNT_W-1:0]     rcdCnt_q, rcdCnt_d;
  logic [CNT_W-1:0]     rasCnt_q, rasCnt_d;
  logic [CNT_W-1:0]     rpCnt_q, rpCnt_d;
  logic [CNT_W-1:0]     wrCnt_q, wrCnt_d;
  logic [CNT_W-1:0]     ccdCnt_q, ccdCnt_d;
  logic                 errPulse_q;
  logic [2:0]           errCode_q;
  logic [7:0]           errCount_q;

  logic       accepted, isAct, isCol, isPre, isIllegal;
  logic       colReady, errHit, rdPush;
  logic [2:0] errSel;

  assign accepted  = cmd_valid && (cmd_bank == 3'(BANK_ID)) && (cmd_op != OP_NOP);
  assign isAct     = (cmd_op == OP_ACT);
  assign isCol     = (cmd_op == OP_RD) || (cmd_op == OP_WR);
  assign isPre     = (cmd_op == OP_PRE);
  assign isIllegal = (cmd_op > OP_PRE);

  // Once tRCD has elapsed the row is usable even before the state register says ACTIVE.
  assign colReady = (state_q == S_ACTIVE) || ((state_q == S_ACTIVATING) && (rcdCnt_q == '0));

  always_comb begin
    state_d   = state_q;
    openRow_d = openRow_q;
    rcdCnt_d  = decSat(rcdCnt_q);
    rasCnt_d  = decSat(rasCnt_q);
    rpCnt_d   = decSat(rpCnt_q);
    wrCnt_d   = decSat(wrCnt_q);
    ccdCnt_d  = decSat(ccdCnt_q);
    errHit    = 1'b0;
    errSel    = ERR_NONE;
    rdPush    = 1'b0;

    case (state_q)
      S_ACTIVATING:  if (rcdCnt_q == '0) state_d = S_ACTIVE;
      S_AP_WAIT: begin
        if ((rasCnt_q == '0) && (wrCnt_q == '0)) begin
          state_d = S_PRECHARGING;
          rpCnt_d = CNT_W'(T_RP - 1);
        end
      end
      S_PRECHARGING: if (rpCnt_q <= CNT_W'(1)) state_d = S_IDLE;
      default: ;
    endcase

    if (accepted) begin
      if (isIllegal) begin
        errHit = 1'b1;
        errSel = ERR_ILLEGAL_OP;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (isAct) begin
              if (rpCnt_q != '0) begin
                errHit = 1'b1;
                errSel = ERR_RP;
              end else begin
                state_d   = S_ACTIVATING;
                openRow_d = cmd_addr;
                rcdCnt_d  = CNT_W'(T_RCD - 1);
                rasCnt_d  = CNT_W'(T_RAS - 1);
              end
            end else if (isCol) begin
              errHit = 1'b1;
              errSel = ERR_COL_CLOSED;
            end
          end
          S_ACTIVATING, S_ACTIVE: begin
            if (isAct) begin
              errHit = 1'b1;
              errSel = ERR_ACT_OPEN;
            end else if (isCol) begin
              if (!colReady) begin
                errHit = 1'b1;
                errSel = ERR_RCD;
              end else if (ccdCnt_q != '0) begin
                errHit = 1'b1;
                errSel = ERR_CCD;
              end else begin
                ccdCnt_d = CNT_W'(T_CCD - 1);
                if (cmd_op == OP_WR) wrCnt_d = CNT_W'(T_WR - 1);
                rdPush  = (cmd_op == OP_RD);
                state_d = cmd_addr[10] ? S_AP_WAIT : S_ACTIVE;
              end
            end else if (isPre) begin
              if (colReady && (rasCnt_q == '0) && (wrCnt_q == '0)) begin
                state_d = S_PRECHARGING;
                rpCnt_d = CNT_W'(T_RP - 1);
              end else begin
                errHit = 1'b1;
                errSel = ERR_PRE_EARLY;
              end
            end
          end
          S_AP_WAIT: begin
            errHit = 1'b1;
            errSel = isAct ? ERR_ACT_OPEN : (isCol ? ERR_COL_CLOSED : ERR_PRE_EARLY);
          end
          S_PRECHARGING: begin
            if (isAct) begin
              errHit = 1'b1;
              errSel = ERR_RP;
            end else if (isCol) begin
              errHit = 1'b1;
              errSel = ERR_COL_CLOSED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      openRow_q  <= '0;
      rcdCnt_q   <= '0;
      rasCnt_q   <= '0;
      rpCnt_q    <= '0;
      wrCnt_q    <= '0;
      ccdCnt_q   <= '0;
      errPulse_q <= 1'b0;
      errCode_q  <= ERR_NONE;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      openRow_q  <= openRow_d;
      rcdCnt_q   <= rcdCnt_d;
      rasCnt_q   <= rasCnt_d;
      rpCnt_q    <= rpCnt_d;
      wrCnt_q    <= wrCnt_d;
      ccdCnt_q   <= ccdCnt_d;
      errPulse_q <= errHit;
      if (errHit) begin
        errCode_q <= errSel;
        if (errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
      end
    end
  end

  rd_latency_pipe #(
    .DEPTH (T_CL),
    .WIDTH (ADDR_BITS)
  ) uRdPipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rdPush),
    .data_i  (cmd_addr),
    .valid_o (rd_valid),
    .data_o  (rd_col)
  );

  assign row_open  = (state_q == S_ACTIVE);
  assign open_row  = openRow_q;
  assign bank_busy = (state_q == S_ACTIVATING) || (state_q == S_PRECHARGING) || (state_q == S_AP_WAIT);
  assign err_pulse = errPulse_q;
  assign err_code  = errCode_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_dram_bank_model.sv
// Directed bench for dram_bank_model (bank 2): timing legality, auto-precharge,
// read latency, error reporting, foreign-bank filtering and mid-operation reset.
module tb_dram_bank_model;

  localparam logic [2:0] BANK  = 3'd2;
  localparam logic [2:0] OTHER = 3'd5;
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [2:0]  cmd_bank = 3'd0;
  logic [13:0] cmd_addr = 14'd0;
  logic        row_open;
  logic [13:0] open_row;
  logic        bank_busy;
  logic        rd_valid;
  logic [13:0] rd_col;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [7:0]  err_count;

  int checkCount = 0;
  int passCount  = 0;

  dram_bank_model #(.BANK_ID(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .row_open  (row_open),
    .open_row  (open_row),
    .bank_busy (bank_busy),
    .rd_valid  (rd_valid),
    .rd_col    (rd_col),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Present one command for exactly one cycle, then return to NOP one step past the sampling edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] bank, input logic [13:0] addr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_bank  = bank;
    cmd_addr  = addr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_addr  = 14'd0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".row_open"},  row_open,  0);
    checkOutput({tag, ".open_row"},  open_row,  0);
    checkOutput({tag, ".bank_busy"}, bank_busy, 0);
    checkOutput({tag, ".rd_valid"},  rd_valid,  0);
    checkOutput({tag, ".rd_col"},    rd_col,    0);
    checkOutput({tag, ".err_pulse"}, err_pulse, 0);
    checkOutput({tag, ".err_code"},  err_code,  0);
    checkOutput({tag, ".err_count"}, err_count, 0);
  endtask

  initial begin
    // Reset for three cycles
    idleCycles(3);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Legal ACT then RD at tRCD: row open from t0+4, read returns at t0+7
    applyStimulus(ACT, BANK, 14'h1A5);
    idleCycles(2);
    checkOutput("t1_rowopen_t3", row_open, 0);
    checkOutput("t1_busy_t3", bank_busy, 1);
    applyStimulus(RD, BANK, 14'h040);
    checkOutput("t1_rowopen_t4", row_open, 1);
    checkOutput("t1_openrow", open_row, 14'h1A5);
    idleCycles(2);
    checkOutput("t1_rdvalid_t6", rd_valid, 0);
    idleCycles(1);
    checkOutput("t1_rdvalid_t7", rd_valid, 1);
    checkOutput("t1_rdcol_t7", rd_col, 14'h040);
    checkOutput("t1_errcount", err_count, 0);
    idleCycles(1);
    checkOutput("t1_rdvalid_t8", rd_valid, 0);
    applyStimulus(PRE, BANK, 14'h0);
    checkOutput("t1_pre_busy", bank_busy, 1);
    idleCycles(2);
    checkOutput("t1_pre_idle", bank_busy, 0);

    // RD one cycle after ACT violates tRCD and returns no data
    applyStimulus(ACT, BANK, 14'h010);
    applyStimulus(RD, BANK, 14'h020);
    checkOutput("t2_errpulse", err_pulse, 1);
    checkOutput("t2_errcode", err_code, 3);
    checkOutput("t2_errcount", err_count, 1);
    idleCycles(1);
    checkOutput("t2_errpulse_off", err_pulse, 0);
    idleCycles(2);
    checkOutput("t2_no_rdvalid", rd_valid, 0);
    idleCycles(1);
    applyStimulus(PRE, BANK, 14'h0);
    idleCycles(2);
    checkOutput("t2_idle", bank_busy, 0);

    // Early PRE after WR, legal retry, then ACT during precharge
    applyStimulus(ACT, BANK, 14'h033);
    idleCycles(2);
    applyStimulus(WR, BANK, 14'h011);
    applyStimulus(PRE, BANK, 14'h0);
    checkOutput("t3_errpulse", err_pulse, 1);
    checkOutput("t3_errcode_pre", err_code, 5);
    checkOutput("t3_errcount", err_count, 2);
    checkOutput("t3_still_open", row_open, 1);
    idleCycles(1);
    applyStimulus(PRE, BANK, 14'h0);
    checkOutput("t3_pre_ok", err_pulse, 0);
    checkOutput("t3_precharging", bank_busy, 1);
    applyStimulus(ACT, BANK, 14'h044);
    checkOutput("t3_errcode_rp", err_code, 6);
    checkOutput("t3_errcount_rp", err_count, 3);
    idleCycles(1);
    checkOutput("t3_idle_busy", bank_busy, 0);
    checkOutput("t3_idle_rowopen", row_open, 0);

    // Auto-precharge read: AP_WAIT until tRAS, precharge, idle at t0+9
    applyStimulus(ACT, BANK, 14'h055);
    idleCycles(2);
    applyStimulus(RD, BANK, 14'h400);
    checkOutput("t4_apwait_busy", bank_busy, 1);
    checkOutput("t4_apwait_rowopen", row_open, 0);
    idleCycles(3);
    checkOutput("t4_rdvalid", rd_valid, 1);
    checkOutput("t4_rdcol", rd_col, 14'h400);
    checkOutput("t4_precharging", bank_busy, 1);
    idleCycles(1);
    checkOutput("t4_busy_t8", bank_busy, 1);
    idleCycles(1);
    checkOutput("t4_idle_t9", bank_busy, 0);
    checkOutput("t4_errcount", err_count, 3);

    // tCCD: second RD too soon is rejected, third at spacing 2 is accepted
    applyStimulus(ACT, BANK, 14'h066);
    idleCycles(2);
    applyStimulus(RD, BANK, 14'h001);
    applyStimulus(RD, BANK, 14'h002);
    checkOutput("t5_errcode_ccd", err_code, 4);
    checkOutput("t5_errcount", err_count, 4);
    applyStimulus(RD, BANK, 14'h003);
    idleCycles(1);
    checkOutput("t5_rd1_valid", rd_valid, 1);
    checkOutput("t5_rd1_col", rd_col, 14'h001);
    idleCycles(1);
    checkOutput("t5_gap", rd_valid, 0);
    idleCycles(1);
    checkOutput("t5_rd2_valid", rd_valid, 1);
    checkOutput("t5_rd2_col", rd_col, 14'h003);
    idleCycles(1);
    checkOutput("t5_after", rd_valid, 0);

    // Commands for another bank are ignored
    applyStimulus(PRE, OTHER, 14'h0);
    applyStimulus(ACT, OTHER, 14'h0AA);
    checkOutput("t6_foreign_open", row_open, 1);
    checkOutput("t6_foreign_row", open_row, 14'h066);
    checkOutput("t6_foreign_nopulse", err_pulse, 0);
    checkOutput("t6_foreign_count", err_count, 4);

    // Illegal op code
    applyStimulus(3'd6, BANK, 14'h0);
    checkOutput("t7_illegal_pulse", err_pulse, 1);
    checkOutput("t7_illegal_code", err_code, 7);
    checkOutput("t7_illegal_count", err_count, 5);

    // Reset one cycle after a RD discards the in-flight read
    applyStimulus(RD, BANK, 14'h077);
    rst_n = 1'b0;
    idleCycles(1);
    checkAllZero("midreset");
    rst_n = 1'b1;
    idleCycles(2);
    checkOutput("t8_no_rdvalid_t4", rd_valid, 0);
    idleCycles(1);
    checkOutput("t8_no_rdvalid_t5", rd_valid, 0);
    checkOutput("t8_state_idle", bank_busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dram_bank_model.md
Name: dram_bank_model

Overview:
- Device-side responder for one DRAM bank. It receives the ACT/RD/WR/PRE command stream that the per-bank controller FSMs issue.
- Tracks open-row state and enforces tRCD/tRAS/tRP/tWR/tCCD. Flags protocol violations and returns read-data-valid strobes CL cycles after each legal RD.
- Instantiated once per bank (BANK_ID 0..7) inside the DRAM interleave test bench/model layer, beside the memory controller.

Parameters:
- BANK_ID, 0, bank this instance responds to (compared against cmd_bank).
- ADDR_BITS, 14, row/column address width.
- T_RCD, 3, min cycles ACT -> RD/WR.
- T_RAS, 6, min cycles ACT -> PRE.
- T_RP, 3, cycles PRE -> next ACT.
- T_CL, 4, cycles RD -> rd_valid.
- T_WR, 3, min cycles WR -> PRE (write recovery).
- T_CCD, 2, min cycles between column commands.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command strobe, one per cycle max.
- cmd_op  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE; others illegal.
- cmd_bank  in  3  target bank; command ignored unless equal to BANK_ID.
- cmd_addr  in  ADDR_BITS  row for ACT, column for RD/WR; cmd_addr[10] = auto-precharge.
- row_open  out  1  bank has an active row (ACTIVE state).
- open_row  out  ADDR_BITS  currently open row.
- bank_busy  out  1  ACTIVATING, PRECHARGING or AP_WAIT.
- rd_valid  out  1  read data strobe, T_CL cycles after accepted RD.
- rd_col  out  ADDR_BITS  column of the read returning with rd_valid.
- err_pulse  out  1  one-cycle strobe on violation.
- err_code  out  3  code of last violation, held: 1 ACT_OPEN, 2 COL_CLOSED, 3 RCD, 4 CCD, 5 PRE_EARLY, 6 RP, 7 ILLEGAL_OP.
- err_count  out  8  saturating violation count (stops at 255).

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, all outputs 0, all counters 0, rd pipeline cleared. Reset mid-operation discards in-flight reads; no rd_valid is emitted after reset.
- A command is accepted when cmd_valid=1, cmd_bank==BANK_ID and op≠NOP. Violating commands do not change state, only report the error.
- States:
  - IDLE: ACT loads open_row=cmd_addr and goes to ACTIVATING with rcd_cnt=T_RCD-1 and ras_cnt=T_RAS-1. ACT is a violation (RP) if rp_cnt≠0. RD/WR → COL_CLOSED. PRE is a legal no-op.
  - ACTIVATING: counts rcd_cnt down; at 0 goes to ACTIVE next cycle. RD/WR here → RCD. ACT → ACT_OPEN. PRE → PRE_EARLY.
  - ACTIVE: row_open=1.
    - RD/WR is legal if ccd_cnt==0. It reloads ccd_cnt=T_CCD-1. WR also loads wr_cnt=T_WR-1. If cmd_addr[10]=1, go to AP_WAIT.
    - PRE is legal if ras_cnt==0 and wr_cnt==0 and goes to PRECHARGING with rp_cnt=T_RP-1; otherwise PRE_EARLY.
    - ACT → ACT_OPEN.
  - AP_WAIT: waits until ras_cnt==0 and wr_cnt==0, then enters PRECHARGING with rp_cnt=T_RP-1. Any accepted command here → PRE_EARLY (PRE) or ACT_OPEN/COL_CLOSED as applicable.
  - PRECHARGING: rp_cnt counts down; at 0 goes to IDLE. ACT → RP. RD/WR → COL_CLOSED. PRE → legal no-op.
- Counters decrement every cycle while nonzero, independent of state, and saturate at 0.
- Read pipeline: a T_CL-deep shift register of {valid, col}. A legal RD enters it in the accept cycle, so rd_valid is high exactly T_CL cycles after the RD cycle. Back-to-back reads at T_CCD spacing produce distinct strobes in order.
- Errors: err_pulse is registered, high in the cycle after the offending command. err_code is updated in the same cycle and held until the next error. err_count increments with saturation. Illegal op codes 5..7 → ILLEGAL_OP.
- Commands whose cmd_bank≠BANK_ID have no effect.

Decomposition:
- Shared package/defines file holds:
  - op encodings (OP_NOP..OP_PRE);
  - error codes;
  - bank state encodings (S_IDLE, S_ACTIVATING, S_ACTIVE, S_AP_WAIT, S_PRECHARGING);
  - default timing constants.
- One natural sub-module: rd_latency_pipe, a parameterised depth-T_CL valid/data shift register.

Test Plan:
- ACT row 0x1A5 at t0, RD col 0x040 at t0+3 → row_open=1 from t0+4, open_row=0x1A5; rd_valid=1 with rd_col=0x040 at t0+7; no error.
- ACT at t0, RD at t0+1 → err_pulse at t0+2, err_code=3, err_count=1; no rd_valid.
- ACT t0, WR t0+3, PRE t0+4 → err_code=5 (tWR/tRAS unmet). PRE retried at t0+6 → accepted; IDLE at t0+9. ACT at t0+7 → err_code=6.
- ACT t0, RD col 0x400 (A10=1) at t0+3 → AP_WAIT, auto-PRECHARGING at t0+6 (tRAS), IDLE at t0+9; rd_valid at t0+7.
- RD t, RD t+1 (tCCD=2) → second RD flagged err_code=4, only one rd_valid. RD at t+2 instead → two rd_valid pulses at t+4 and t+6 in order.
- Command with cmd_bank≠BANK_ID → no state change. Assert rst_n=0 one cycle after a RD → no rd_valid, all outputs 0.
